// File: rtl/uart_pattern_tx_if.sv
// Control and status bundle for uart_pattern_tx.
// master = stimulus/controller side, slave = the pattern transmitter.
interface uart_pattern_tx_if;
  logic        en;
  logic [1:0]  mode;
  logic [7:0]  const_byte;
  logic        tx;
  logic        busy;
  logic        byte_sent;
  logic [7:0]  last_byte;
  logic [15:0] frame_cnt;

  modport master (
    output en, mode, const_byte,
    input  tx, busy, byte_sent, last_byte, frame_cnt
  );

  modport slave (
    input  en, mode, const_byte,
    output tx, busy, byte_sent, last_byte, frame_cnt
  );
endinterface

// File: rtl/uart_pattern_tx.sv
// UART test-pattern source (count / walking-one / constant / LFSR) with its own 8-bit serializer.
// Define UART_PATTERN_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_pattern_tx #(
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned F          = 50000000,
  parameter int unsigned GAP_CYCLES = 1024,
  parameter int unsigned WRAP       = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input logic              clk,
  input logic              rst,
  uart_pattern_tx_if.slave bus_if
);

  localparam int unsigned CLKS_PER_BIT = F / BAUD;
  localparam int unsigned DIV_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned GAP_W        = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [2:0]  STOP_LAST    = 3'(STOP_BITS - 1);

  localparam logic [1:0] MODE_COUNT = 2'b00;
  localparam logic [1:0] MODE_WALK  = 2'b01;
  localparam logic [1:0] MODE_CONST = 2'b10;
  localparam logic [1:0] MODE_LFSR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_START,
    S_DATA,
`ifdef UART_PATTERN_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e             state_q;
  logic [DIV_W-1:0]   div_q;
  logic [GAP_W-1:0]   gap_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;
  logic [7:0]         payload_q;
  logic [1:0]         mode_q;
  logic [7:0]         count_q;
  logic [7:0]         walk_q;
  logic [7:0]         lfsr_q;
  logic               tx_q;
  logic               busy_q;
  logic               byte_sent_q;
  logic [7:0]         last_byte_q;
  logic [15:0]        frame_cnt_q;

  logic [7:0] count_d;
  logic [7:0] walk_d;
  logic [7:0] lfsr_d;
  logic [7:0] payload_d;
  logic       div_last;
  logic       div_prelast;

  assign div_last    = (div_q == DIV_W'(CLKS_PER_BIT - 1));
  assign div_prelast = (div_q == DIV_W'(CLKS_PER_BIT - 2));

  // Generator successors and the payload chosen at frame start
  always_comb begin
    count_d   = (count_q == 8'(WRAP - 1)) ? 8'd0 : count_q + 8'd1;
    walk_d    = {walk_q[6:0], walk_q[7]};
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    payload_d = count_q;
    case (bus_if.mode)
      MODE_COUNT: payload_d = count_q;
      MODE_WALK:  payload_d = walk_q;
      MODE_CONST: payload_d = bus_if.const_byte;
      MODE_LFSR:  payload_d = lfsr_q;
      default:    payload_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      gap_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      payload_q   <= '0;
      mode_q      <= MODE_COUNT;
      count_q     <= 8'h00;
      walk_q      <= 8'h01;
      lfsr_q      <= 8'h01;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      byte_sent_q <= 1'b0;
      last_byte_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      byte_sent_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (bus_if.en) begin
            state_q <= S_GAP;
            gap_q   <= '0;
          end
        end

        S_GAP: begin
          if (!bus_if.en) begin
            state_q <= S_IDLE;
          end else if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
            payload_q <= payload_d;
            shift_q   <= payload_d;
            mode_q    <= bus_if.mode;
            div_q     <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_START;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end

        S_START: begin
          if (div_last) begin
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            state_q <= S_DATA;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        S_DATA: begin
          if (div_last) begin
            div_q <= '0;
            if (bit_q == 3'd7) begin
              bit_q <= '0;
`ifdef UART_PATTERN_PARITY_EN
              tx_q    <= ^payload_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

`ifdef UART_PATTERN_PARITY_EN
        S_PARITY: begin
          if (div_last) begin
            div_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
`endif

        S_STOP: begin
          tx_q <= 1'b1;
          // Raised one clock early so the registered pulse lands on the final stop clock
          byte_sent_q <= (bit_q == STOP_LAST) && div_prelast;
          if (div_last) begin
            div_q <= '0;
            if (bit_q == STOP_LAST) begin
              bit_q       <= '0;
              busy_q      <= 1'b0;
              last_byte_q <= payload_q;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              case (mode_q)
                MODE_COUNT: count_q <= count_d;
                MODE_WALK:  walk_q  <= walk_d;
                MODE_LFSR:  lfsr_q  <= lfsr_d;
                default:    ;
              endcase
              gap_q   <= '0;
              state_q <= bus_if.en ? S_GAP : S_IDLE;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.tx        = tx_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.byte_sent = byte_sent_q;
  assign bus_if.last_byte = last_byte_q;
  assign bus_if.frame_cnt = frame_cnt_q;

endmodule
